// File: rtl/add_pkg.sv
// Shared definitions for the shared approximate-adder arbiter: FSM encoding and default widths.
package add_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int BWOP_DEF = 32;
  localparam int NAB_DEF  = 0;
endpackage

// File: rtl/bta.sv
// Approximate adder: NAB low bits are the OR of the operands, the upper part is an exact sum
// whose carry-in is the AND of the top approximate bit pair. NAB=0 is an exact adder.
module bta #(
  parameter int BWOP = 32,
  parameter int NAB  = 0
) (
  input  logic [BWOP-1:0] a,
  input  logic [BWOP-1:0] b,
  output logic [BWOP-1:0] c
);
  generate
    if (NAB == 0) begin : g_exact
      assign c = a + b;
    end else begin : g_approx
      logic cin;
      assign cin          = a[NAB-1] & b[NAB-1];
      assign c[NAB-1:0]   = a[NAB-1:0] | b[NAB-1:0];
      assign c[BWOP-1:NAB] = a[BWOP-1:NAB] + b[BWOP-1:NAB] + (BWOP-NAB)'(cin);
    end
  endgenerate
endmodule

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: first requester at or above ptr wins, wrapping to index 0.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  logic hit;

  // Two passes: upper segment [ptr, NREQ-1] first, then the wrapped segment [0, ptr-1].
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      hit    = !any && req[i] && (i >= int'(ptr));
      gnt[i] = hit;
      idx    = hit ? IDW'(i) : idx;
      any    = any | hit;
    end
    for (int i = 0; i < NREQ; i++) begin
      hit    = !any && req[i] && (i < int'(ptr));
      gnt[i] = gnt[i] | hit;
      idx    = hit ? IDW'(i) : idx;
      any    = any | hit;
    end
  end
endmodule

// File: rtl/add_share_arb.sv
// One registered approximate adder shared by NREQ requesters under round-robin arbitration,
// with an enable/drain FSM and saturating per-requester grant counters.
module add_share_arb
  import add_pkg::*;
#(
  parameter int BWOP = BWOP_DEF,
  parameter int NAB  = NAB_DEF,
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*BWOP-1:0] req_a,
  input  logic [NREQ*BWOP-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BWOP-1:0]      rsp_c,
  output logic [IDW-1:0]       rsp_id,
  output logic                 idle,
  output logic [NREQ*CNTW-1:0] gnt_cnt
);
  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            gany;
  logic            free;
  logic            grant_ok;
  logic            xfer;
  logic [BWOP-1:0] op_a, op_b, sum;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid), .ptr(ptr), .gnt(gnt), .idx(gidx), .any(gany)
  );

  assign free      = !rsp_valid || rsp_ready;
  assign grant_ok  = (state == ST_RUN) && free && !rst;
  assign req_ready = grant_ok ? gnt : '0;
  assign xfer      = grant_ok && gany;
  assign op_a      = req_a[gidx*BWOP +: BWOP];
  assign op_b      = req_b[gidx*BWOP +: BWOP];
  assign idle      = (state == ST_IDLE) && !rsp_valid;

  bta #(BWOP, NAB) u_add (.a(op_a), .b(op_b), .c(sum));

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state; re-enable from DRAIN wins over finishing the drain
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = en ? ST_RUN : ST_IDLE;
      ST_RUN:   state_nxt = en ? ST_RUN : ST_DRAIN;
      ST_DRAIN: begin
        if (en)                          state_nxt = ST_RUN;
        else if (!rsp_valid || rsp_ready) state_nxt = ST_IDLE;
        else                             state_nxt = ST_DRAIN;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Result register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_c     <= sum;
      rsp_id    <= gidx;
      ptr       <= (gidx == IDW'(NREQ-1)) ? '0 : gidx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Saturating grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i] && gnt_cnt[i*CNTW +: CNTW] != {CNTW{1'b1}})
          gnt_cnt[i*CNTW +: CNTW] <= gnt_cnt[i*CNTW +: CNTW] + CNTW'(1);
      end
    end
  end
endmodule

// File: tb/tb_add_share_arb.sv
// Randomised and directed bench for add_share_arb against a transaction-level reference model.
module tb_add_share_arb;
  import add_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic [3:0]   req_valid = 4'b0000;
  logic [3:0]   req_ready;
  logic [127:0] req_a = 128'd0;
  logic [127:0] req_b = 128'd0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [31:0]  rsp_c;
  logic [1:0]   rsp_id;
  logic         idle;
  logic [63:0]  gnt_cnt;

  logic         rst2 = 1'b1;
  logic         en2 = 1'b0;
  logic [3:0]   v2 = 4'b0000;
  logic [3:0]   ready2;
  logic [127:0] a2 = 128'd0;
  logic [127:0] b2 = 128'd0;
  logic         rsp_valid2;
  logic         rsp_ready2 = 1'b1;
  logic [31:0]  c2;
  logic [1:0]   id2;
  logic         idle2;
  logic [7:0]   cnt2;

  int n_checks = 0;
  int n_errors = 0;

  add_share_arb #(.BWOP(32), .NAB(0), .NREQ(4), .IDW(2), .CNTW(16)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .rsp_id(rsp_id), .idle(idle), .gnt_cnt(gnt_cnt)
  );

  add_share_arb #(.BWOP(32), .NAB(4), .NREQ(4), .IDW(2), .CNTW(2)) dut2 (
    .clk(clk), .rst(rst2), .en(en2), .req_valid(v2), .req_ready(ready2),
    .req_a(a2), .req_b(b2), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_c(c2), .rsp_id(id2), .idle(idle2), .gnt_cnt(cnt2)
  );

  always #5 clk = ~clk;

  // Reference model: 0=idle, 1=run, 2=drain
  int          m_state = 0;
  int          m_ptr = 0;
  bit          m_valid = 1'b0;
  logic [31:0] m_c = 32'd0;
  int          m_id = 0;
  int          m_cnt[4] = '{0, 0, 0, 0};
  logic [3:0]  exp_ready = 4'b0000;
  int          exp_idx = -1;

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input int nab);
    logic [31:0] mask, hi;
    int cin;
    if (nab == 0) return a + b;
    mask = (32'd1 << nab) - 32'd1;
    cin  = ((a >> (nab - 1)) & (b >> (nab - 1)) & 32'd1) != 0 ? 1 : 0;
    hi   = (a >> nab) + (b >> nab) + cin;
    return (hi << nab) | ((a | b) & mask);
  endfunction

  function automatic void model_comb();
    exp_ready = 4'b0000;
    exp_idx   = -1;
    if (!rst && m_state == 1 && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < 4; k++) begin
        int j;
        j = (m_ptr + k) % 4;
        if (exp_idx < 0 && req_valid[j]) begin
          exp_idx      = j;
          exp_ready[j] = 1'b1;
        end
      end
    end
  endfunction

  task automatic settle();
    #1;
    model_comb();
  endtask

  // Advance one clock: model update mirrors the transaction rules, then outputs settle.
  task automatic tick();
    int nstate;
    @(posedge clk);
    if (rst) begin
      m_state = 0; m_ptr = 0; m_valid = 1'b0; m_c = 32'd0; m_id = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      nstate = m_state;
      if (m_state == 0 && en) nstate = 1;
      else if (m_state == 1 && !en) nstate = 2;
      else if (m_state == 2 && en) nstate = 1;
      else if (m_state == 2 && (!m_valid || rsp_ready)) nstate = 0;
      if (exp_idx >= 0) begin
        m_valid = 1'b1;
        m_c     = ref_add(req_a[exp_idx*32 +: 32], req_b[exp_idx*32 +: 32], 0);
        m_id    = exp_idx;
        if (m_cnt[exp_idx] < 65535) m_cnt[exp_idx]++;
        m_ptr   = (exp_idx + 1) % 4;
      end else if (rsp_ready) begin
        m_valid = 1'b0;
      end
      m_state = nstate;
    end
    #1;
  endtask

  task automatic drive(input logic e, input logic [3:0] v, input logic rr);
    @(negedge clk);
    en = e; req_valid = v; rsp_ready = rr;
    settle();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b1;
    settle();
    n_checks++;
    if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    tick();
    @(negedge clk);
    rst = 1'b0; en = 1'b0; req_valid = 4'b0000;
    settle();
    n_checks++;
    if ({rsp_valid, rsp_c, rsp_id, idle} !== {1'b0, 32'd0, 2'd0, 1'b1}) begin
      n_errors++; $display("FAIL reset_outputs: got v=%b c=%h id=%0d idle=%b expected 0 0 0 1", rsp_valid, rsp_c, rsp_id, idle);
    end
    n_checks++;
    if (gnt_cnt !== 64'd0) begin n_errors++; $display("FAIL reset_cnt: got %h expected 0", gnt_cnt); end
  endtask

  task automatic test_single();
    req_a[31:0] = 32'd5; req_b[31:0] = 32'd7;
    drive(1'b1, 4'b0001, 1'b1);
    tick();
    drive(1'b1, 4'b0001, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b expected 0001", req_ready); end
    tick();
    n_checks++;
    if ({rsp_valid, rsp_c, rsp_id} !== {1'b1, 32'd12, 2'd0}) begin
      n_errors++; $display("FAIL single_result: got v=%b c=%0d id=%0d expected 1 12 0", rsp_valid, rsp_c, rsp_id);
    end
  endtask

  task automatic test_round_robin();
    @(negedge clk); rst = 1'b1; settle(); tick();
    @(negedge clk); rst = 1'b0; settle();
    for (int i = 0; i < 4; i++) begin req_a[i*32 +: 32] = 32'd100 * i; req_b[i*32 +: 32] = 32'd3 + i; end
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 4'b1111, 1'b1);
      n_checks++;
      if (req_ready !== (4'b0001 << (k % 4))) begin
        n_errors++; $display("FAIL rr_order[%0d]: got %b expected %b", k, req_ready, 4'b0001 << (k % 4));
      end
      tick();
      n_checks++;
      if (rsp_id !== 2'(k % 4) || rsp_c !== 32'd100 * (k % 4) + 32'd3 + (k % 4)) begin
        n_errors++; $display("FAIL rr_result[%0d]: got id=%0d c=%0d", k, rsp_id, rsp_c);
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (gnt_cnt[i*16 +: 16] !== 16'd2) begin n_errors++; $display("FAIL rr_cnt[%0d]: got %0d expected 2", i, gnt_cnt[i*16 +: 16]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held_c;
    logic [1:0]  held_id;
    held_c = rsp_c; held_id = rsp_id;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 4'b1111, 1'b0);
      n_checks++;
      if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, req_ready); end
      tick();
      n_checks++;
      if ({rsp_valid, rsp_c, rsp_id} !== {1'b1, held_c, held_id}) begin
        n_errors++; $display("FAIL bp_hold[%0d]: got v=%b c=%h id=%0d expected 1 %h %0d", k, rsp_valid, rsp_c, rsp_id, held_c, held_id);
      end
    end
    drive(1'b1, 4'b1111, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0001 || req_ready !== exp_ready) begin
      n_errors++; $display("FAIL bp_release: got %b expected 0001", req_ready);
    end
    tick();
  endtask

  task automatic test_drain();
    drive(1'b1, 4'b1111, 1'b0);
    tick();
    drive(1'b0, 4'b1111, 1'b0);
    tick();
    n_checks++;
    if (dut.state !== ST_DRAIN) begin n_errors++; $display("FAIL drain_state: got %0d expected 2", dut.state); end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 4'b1111, 1'b0);
      n_checks++;
      if (req_ready !== 4'b0000 || idle !== 1'b0) begin
        n_errors++; $display("FAIL drain_hold[%0d]: got ready=%b idle=%b expected 0000 0", k, req_ready, idle);
      end
      tick();
    end
    drive(1'b0, 4'b1111, 1'b1);
    tick();
    n_checks++;
    if (idle !== 1'b1 || rsp_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_idle: got idle=%b v=%b expected 1 0", idle, rsp_valid);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 4'b1111, 1'b1);
      n_checks++;
      if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL drain_noready[%0d]: got %b expected 0000", k, req_ready); end
      tick();
    end
  endtask

  task automatic test_carry();
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    req_a[31:0] = 32'hFFFF_FFFF; req_b[31:0] = 32'd1;
    drive(1'b1, 4'b0001, 1'b1);
    tick();
    n_checks++;
    if ({rsp_valid, rsp_c} !== {1'b1, 32'd0}) begin
      n_errors++; $display("FAIL carry_drop: got v=%b c=%h expected 1 00000000", rsp_valid, rsp_c);
    end
  endtask

  task automatic test_random();
    logic [31:0] op_a[4], op_b[4];
    for (int i = 0; i < 4; i++) begin op_a[i] = req_a[i*32 +: 32]; op_b[i] = req_b[i*32 +: 32]; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (!(req_valid[i] && !exp_ready[i])) begin op_a[i] = $urandom; op_b[i] = $urandom; end
        req_a[i*32 +: 32] = op_a[i]; req_b[i*32 +: 32] = op_b[i];
      end
      req_valid = 4'($urandom);
      en        = ($urandom_range(0, 9) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      settle();
      n_checks++;
      if (req_ready !== exp_ready) begin n_errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", cyc, req_ready, exp_ready); end
      tick();
      n_checks++;
      if (rsp_valid !== m_valid || idle !== (m_state == 0 && !m_valid)) begin
        n_errors++; $display("FAIL rand_status[%0d]: got v=%b idle=%b expected v=%b state=%0d", cyc, rsp_valid, idle, m_valid, m_state);
      end
      if (m_valid) begin
        n_checks++;
        if (rsp_c !== m_c || rsp_id !== 2'(m_id)) begin
          n_errors++; $display("FAIL rand_result[%0d]: got c=%h id=%0d expected c=%h id=%0d", cyc, rsp_c, rsp_id, m_c, m_id);
        end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (gnt_cnt[i*16 +: 16] !== 16'(m_cnt[i])) begin
          n_errors++; $display("FAIL rand_cnt[%0d][%0d]: got %0d expected %0d", cyc, i, gnt_cnt[i*16 +: 16], m_cnt[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 4'b0000, 1'b1);
    tick();
    drive(1'b1, 4'b0110, 1'b0);
    tick();
    drive(1'b1, 4'b0110, 1'b0);
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL rstmid_held: got v=%b expected 1", rsp_valid); end
    @(negedge clk); rst = 1'b1; settle(); tick();
    @(negedge clk); rst = 1'b0; req_valid = 4'b0000; rsp_ready = 1'b0; settle();
    n_checks++;
    if (rsp_valid !== 1'b0 || gnt_cnt !== 64'd0) begin
      n_errors++; $display("FAIL rstmid_clear: got v=%b cnt=%h expected 0 0", rsp_valid, gnt_cnt);
    end
    tick();
    drive(1'b1, 4'b1111, 1'b1);
    n_checks++;
    if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL rstmid_ptr: got %b expected 0001", req_ready); end
    tick();
  endtask

  task automatic test_approx_sat();
    logic [31:0] pa, pb;
    bit          pend;
    pend = 1'b0;
    @(negedge clk); rst2 = 1'b0; en2 = 1'b1; v2 = 4'b0001; rsp_ready2 = 1'b1;
    a2[31:0] = 32'h0000_000F; b2[31:0] = 32'h0000_0008;
    for (int k = 0; k < 6; k++) begin
      if (k > 1) begin a2[31:0] = $urandom; b2[31:0] = $urandom; end
      #1;
      n_checks++;
      if (ready2 !== ((k == 0) ? 4'b0000 : 4'b0001)) begin n_errors++; $display("FAIL approx_ready[%0d]: got %b", k, ready2); end
      pend = ready2[0]; pa = a2[31:0]; pb = b2[31:0];
      @(posedge clk); #1;
      if (pend) begin
        n_checks++;
        if (rsp_valid2 !== 1'b1 || c2 !== ref_add(pa, pb, 4)) begin
          n_errors++; $display("FAIL approx_sum[%0d]: got %h expected %h", k, c2, ref_add(pa, pb, 4));
        end
      end
      if (k == 1) begin
        n_checks++;
        if (c2 !== 32'h0000_001F) begin n_errors++; $display("FAIL approx_directed: got %h expected 0000001f", c2); end
      end
      @(negedge clk);
    end
    n_checks++;
    if (cnt2[1:0] !== 2'd3 || cnt2[7:2] !== 6'd0) begin n_errors++; $display("FAIL sat_cnt: got %h expected 03", cnt2); end
    en2 = 1'b0; v2 = 4'b0000;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_carry();
    test_random();
    test_reset_mid();
    test_approx_sat();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
